btn_cond: RTL and testbench

- Input conditioner for the computer's parallel input ports (PORTI buttons, PORTJ switches).
- Sits directly upstream of comp: raw pad / bench stimulus goes in, debounced levels go out to PORTI/PORTJ.
- Each bit is synchronised, sampled on a shared prescaled tick and debounced.
- Per-bit rise/fall pulses and a software-clearable sticky "pressed" latch are produced alongside the level.

---
 rtl/btn_cond.sv | 99 +++++++++
 tb/tb_btn_cond.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// Parallel input conditioner: 2-FF synchroniser, shared prescaled sample tick,
// STABLE-sample debounce, with per-bit rise/fall pulses and a clearable pressed latch.
module btn_cond #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned TICK_W   = 16,
  parameter int unsigned STABLE   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] pressed,
  output logic             tick
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [WIDTH-1:0]  s1_q, s2_q;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [WIDTH-1:0]  hist_q [STABLE];
  logic [WIDTH-1:0]  hist_d [STABLE];
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  rise_q, rise_d;
  logic [WIDTH-1:0]  fall_q, fall_d;
  logic [WIDTH-1:0]  pressed_q, pressed_d;
  logic [WIDTH-1:0]  all1, all0;

  always_comb begin
    cnt_d  = (cnt_q == TICK_LAST) ? '0 : cnt_q + TICK_W'(1);
    tick_d = (cnt_q == TICK_LAST);

    for (int unsigned k = 0; k < STABLE; k++) begin
      hist_d[k] = hist_q[k];
    end
    if (tick_q) begin
      hist_d[0] = s2_q;
      for (int unsigned k = 1; k < STABLE; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end

    // Level decision uses the post-shift history so dout moves on the sampling edge itself.
    all1 = '1;
    all0 = '1;
    for (int unsigned k = 0; k < STABLE; k++) begin
      all1 = all1 & hist_d[k];
      all0 = all0 & ~hist_d[k];
    end

    dout_d = dout_q;
    if (tick_q) begin
      dout_d = (dout_q | all1) & ~all0;
    end

    rise_d    = dout_d & ~dout_q;
    fall_d    = ~dout_d & dout_q;
    pressed_d = (pressed_q & ~clr) | rise_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      dout_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pressed_q <= '0;
      for (int unsigned k = 0; k < STABLE; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      s1_q      <= din;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      dout_q    <= dout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pressed_q <= pressed_d;
      for (int unsigned k = 0; k < STABLE; k++) begin
        hist_q[k] <= hist_d[k];
      end
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign pressed = pressed_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond: two configurations share stimulus, each with its own
// run-length reference model; a monitor compares every cycle's outputs after the edge.
module tb_btn_cond;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pressed;
    logic         tick;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] clr = '0;

  logic [W-1:0] a_dout, a_rise, a_fall, a_pressed;
  logic [W-1:0] b_dout, b_rise, b_fall, b_pressed;
  logic         a_tick, b_tick;

  always #5 clk = ~clk;

  btn_cond #(.WIDTH(W), .TICK_DIV(4), .TICK_W(4), .STABLE(3)) u_a (
    .clk(clk), .reset(reset), .din(din), .clr(clr),
    .dout(a_dout), .rise(a_rise), .fall(a_fall), .pressed(a_pressed), .tick(a_tick)
  );

  btn_cond #(.WIDTH(W), .TICK_DIV(1), .TICK_W(2), .STABLE(2)) u_b (
    .clk(clk), .reset(reset), .din(din), .clr(clr),
    .dout(b_dout), .rise(b_rise), .fall(b_fall), .pressed(b_pressed), .tick(b_tick)
  );

  int checks = 0;
  int failures = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  // Reference model state, index 0 = config A, 1 = config B.
  int           md[2] = '{4, 1};
  int           ms[2] = '{3, 2};
  int           n[2];
  logic [W-1:0] s1m[2], s2m[2], lvl[2], prs[2];
  logic         rv[2][W];
  int           rl[2][W];

  function automatic void model_reset(int i);
    n[i]   = 0;
    s1m[i] = '0;
    s2m[i] = '0;
    lvl[i] = '0;
    prs[i] = '0;
    for (int b = 0; b < W; b++) begin
      rv[i][b] = 1'b0;
      rl[i][b] = ms[i];
    end
  endfunction

  // One clock edge: a sample is taken on edges whose preceding tick was high;
  // a level changes once the last STABLE samples all disagree with it.
  function automatic exp_t model_step(int i, logic [W-1:0] d, logic [W-1:0] c, logic rst_n);
    exp_t e;
    logic [W-1:0] r, f;
    bit smp;
    r = '0;
    f = '0;
    if (!rst_n) begin
      model_reset(i);
      e.dout = '0; e.rise = '0; e.fall = '0; e.pressed = '0; e.tick = 1'b0;
      return e;
    end
    n[i]++;
    smp = (n[i] >= 2) && (((n[i] - 1) % md[i]) == 0);
    if (smp) begin
      for (int b = 0; b < W; b++) begin
        if (s2m[i][b] == rv[i][b]) begin
          if (rl[i][b] < 1000) rl[i][b]++;
        end else begin
          rv[i][b] = s2m[i][b];
          rl[i][b] = 1;
        end
        if (rl[i][b] >= ms[i] && rv[i][b] != lvl[i][b]) begin
          lvl[i][b] = rv[i][b];
          if (rv[i][b]) r[b] = 1'b1;
          else          f[b] = 1'b1;
        end
      end
    end
    prs[i] = (prs[i] & ~c) | r;
    s2m[i] = s1m[i];
    s1m[i] = d;
    e.dout    = lvl[i];
    e.rise    = r;
    e.fall    = f;
    e.pressed = prs[i];
    e.tick    = ((n[i] % md[i]) == 0);
    return e;
  endfunction

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endfunction

  task automatic cyc(input logic [W-1:0] d, input logic [W-1:0] c, input logic rst_n);
    @(negedge clk);
    din   = d;
    clr   = c;
    reset = rst_n;
    sb_a.push_back(model_step(0, d, c, rst_n));
    sb_b.push_back(model_step(1, d, c, rst_n));
  endtask

  task automatic hold(input logic [W-1:0] d, input logic [W-1:0] c, input int cycles);
    for (int k = 0; k < cycles; k++) cyc(d, c, 1'b1);
  endtask

  // Monitor: each expectation is consumed just after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        chk("A.dout", a_dout, e.dout);
        chk("A.rise", a_rise, e.rise);
        chk("A.fall", a_fall, e.fall);
        chk("A.pressed", a_pressed, e.pressed);
        chk("A.tick", {31'b0, a_tick}, {31'b0, e.tick});
        chk("A.rise_fall_excl", a_rise & a_fall, '0);
      end
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        chk("B.dout", b_dout, e.dout);
        chk("B.rise", b_rise, e.rise);
        chk("B.fall", b_fall, e.fall);
        chk("B.pressed", b_pressed, e.pressed);
        chk("B.tick", {31'b0, b_tick}, {31'b0, e.tick});
      end
    end
  end

  initial begin
    logic [W-1:0] rd, rc;
    int len;
    model_reset(0);
    model_reset(1);

    // Reset with inputs high, then release and let all bits debounce high.
    for (int k = 0; k < 3; k++) cyc('1, '0, 1'b0);
    hold('1, '0, 24);
    hold('0, '0, 20);
    hold('0, '1, 3);

    // Single-bit latency and fall.
    hold(32'h4, '0, 10);
    hold('0, '0, 10);

    // Short glitch, then a long pulse on bit 2.
    hold(32'h4, '0, 3);
    hold('0, '0, 20);
    hold(32'h4, '0, 20);
    hold('0, '0, 20);

    // Bouncing press on bit 0.
    for (int k = 0; k < 8; k++) begin
      hold(32'h1, '0, 1);
      hold('0, '0, 1);
    end
    hold(32'h1, '0, 20);
    hold('0, '0, 20);

    // Pressed/clr race on bit 1: set pressed, drop, then rise again under clr.
    hold(32'h2, '0, 20);
    hold('0, '0, 20);
    hold(32'h2, 32'h2, 20);
    hold(32'h2, '0, 3);
    hold(32'h2, 32'h2, 2);
    hold('0, '0, 20);

    // Mid-debounce reset with input held high.
    hold('1, '0, 9);
    cyc('1, '0, 1'b0);
    cyc('1, '0, 1'b0);
    hold('1, '0, 24);
    hold('0, '1, 20);

    // Randomised segments.
    for (int s = 0; s < 120; s++) begin
      rd  = $urandom();
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) cyc(rd, '0, 1'b0);
      end
      for (int k = 0; k < len; k++) begin
        rc = ($urandom_range(0, 3) == 0) ? W'($urandom()) : '0;
        cyc(rd, rc, 1'b1);
      end
    end
    hold('0, '0, 20);

    @(posedge clk);
    #3;
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_a.size() + sb_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
